multiplier_booth_n: RTL and testbench

Parametrised radix-2 Booth sequential multiplier, generalising the fixed 8-bit shift-add multiplier to any operand width with a Start/Busy/Done handshake and a held 2×WIDTH product register. It sits behind the synchronised switch/button front end (or any internal master) and is consumed by the hex display path or downstream datapath logic. Operands are captured once per operation; one Booth add/subtract-and-shift step executes per clock.

---
 rtl/mult_pkg.sv | 29 ++
 rtl/booth_add_sub.sv | 40 ++++
 rtl/multiplier_booth_n.sv | 126 ++++++++++++
 tb/tb_multiplier_booth_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP,
    BOOTH_ADD,
    BOOTH_SUB
  } booth_op_t;

  localparam int unsigned MULT_MAX_WIDTH = 32;

  // Radix-2 Booth recoding of the current multiplier LSB and the saved bit below it.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_add_sub.sv
// Combinational (WIDTH+1)-bit adder/subtractor for one Booth step.
// Subtraction is formed as A + ~M + 1 so a single adder serves both operations.
module booth_add_sub
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] m,
  input  booth_op_t      op,
  output logic [WIDTH:0] result
);

  localparam int unsigned XW = WIDTH + 1;

  logic [WIDTH:0] m_eff;
  logic           cin;

  // Select the addend and carry-in for the requested Booth operation.
  always_comb begin
    m_eff = '0;
    cin   = 1'b0;
    case (op)
      BOOTH_ADD: begin
        m_eff = m;
        cin   = 1'b0;
      end
      BOOTH_SUB: begin
        m_eff = ~m;
        cin   = 1'b1;
      end
      default: begin
        m_eff = '0;
        cin   = 1'b0;
      end
    endcase
    result = a + m_eff + XW'(cin);
  end

endmodule

// File: rtl/multiplier_booth_n.sv
// Parametrised radix-2 Booth sequential multiplier with Start/Busy/Done handshake.
// One add/subtract-and-shift step per clock, WIDTH+1 steps per operation on
// WIDTH+1-bit extended operands; 2*WIDTH-bit product register held between operations.
// Optional feature macro: MULT_SIGNED_SEL_EN adds the Signed_Mode port
// (1 = two's complement, 0 = unsigned); without it operation is always signed.
module multiplier_booth_n
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
`ifdef MULT_SIGNED_SEL_EN
  input  logic                 Signed_Mode,
`endif
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

  mult_state_t        state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     q_q, q_d;
  logic [WIDTH:0]     m_q, m_d;
  logic               q_1_q, q_1_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               signed_sel;
  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     q_ext;
  booth_op_t          step_op;
  logic [WIDTH:0]     step_sum;

`ifdef MULT_SIGNED_SEL_EN
  assign signed_sel = Signed_Mode;
`else
  assign signed_sel = 1'b1;
`endif

  // Extend operands by one bit: sign bit in signed mode, zero otherwise.
  assign m_ext = {signed_sel & Multiplicand[WIDTH-1], Multiplicand};
  assign q_ext = {signed_sel & Multiplier[WIDTH-1], Multiplier};

  assign step_op = booth_decode(q_q[0], q_1_q);

  booth_add_sub #(
    .WIDTH (WIDTH)
  ) u_add_sub (
    .a      (a_q),
    .m      (m_q),
    .op     (step_op),
    .result (step_sum)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      q_1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      q_1_q     <= q_1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update: capture, Booth iterate, publish product.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    q_1_d     = q_1_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          m_d     = m_ext;
          q_d     = q_ext;
          a_d     = '0;
          q_1_d   = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (count_q == CW'(WIDTH + 1)) begin
          product_d = {a_q[WIDTH-2:0], q_q};
          state_d   = DONE;
        end else begin
          // Arithmetic shift right of {sum, Q, Q_1}, replicating the sum MSB.
          {a_d, q_d, q_1_d} = {step_sum[WIDTH], step_sum, q_q};
          count_d           = count_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode directly from the state register.
  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE);
  assign Product = product_q;

endmodule

// File: tb/tb_multiplier_booth_n.sv
// Directed bench for multiplier_booth_n (WIDTH=8 and WIDTH=16 instances) with a
// cycle-level reference model and per-cycle comparison of Busy/Done/Product.
module tb_multiplier_booth_n;

  localparam int W8  = 8;
  localparam int W16 = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  mc8 = '0, mp8 = '0;
  logic [15:0] mc16 = '0, mp16 = '0;
  logic        sgn8 = 1'b1, sgn16 = 1'b1;
  logic        busy8, done8, busy16, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  multiplier_booth_n #(.WIDTH(W8)) dut8 (
    .Clk(clk), .Reset(rst), .Start(start8),
    .Multiplicand(mc8), .Multiplier(mp8),
`ifdef MULT_SIGNED_SEL_EN
    .Signed_Mode(sgn8),
`endif
    .Busy(busy8), .Done(done8), .Product(prod8)
  );

  multiplier_booth_n #(.WIDTH(W16)) dut16 (
    .Clk(clk), .Reset(rst), .Start(start16),
    .Multiplicand(mc16), .Multiplier(mp16),
`ifdef MULT_SIGNED_SEL_EN
    .Signed_Mode(sgn16),
`endif
    .Busy(busy16), .Done(done16), .Product(prod16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference product: interpret w-bit operands, multiply, keep 2w bits.
  function automatic longint ref_mul(input longint a, input longint b, input int w, input bit sgn);
    longint sa, sb, p;
    sa = a;
    sb = b;
    if (sgn && a[w-1]) sa = a - (longint'(1) << w);
    if (sgn && b[w-1]) sb = b - (longint'(1) << w);
    p = sa * sb;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  function automatic bit eff_sgn(input bit s);
`ifdef MULT_SIGNED_SEL_EN
    return s;
`else
    return 1'b1;
`endif
  endfunction

  // Model: k = edges since the accepting edge (0 = idle). Busy for k in 1..W+2,
  // Done at k = W+3 (W+2 edges after acceptance), product published then.
  int     k8 = 0, k16 = 0;
  longint res8 = 0, res16 = 0, eprod8 = 0, eprod16 = 0;

  always @(posedge clk) begin
    if (rst) begin
      k8 <= 0; eprod8 <= 0;
    end else if (k8 == 0) begin
      if (start8) begin
        k8   <= 1;
        res8 <= ref_mul(longint'(mc8), longint'(mp8), W8, eff_sgn(sgn8));
      end
    end else if (k8 == W8 + 3) begin
      k8 <= 0;
    end else begin
      k8 <= k8 + 1;
      if (k8 + 1 == W8 + 3) eprod8 <= res8;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      k16 <= 0; eprod16 <= 0;
    end else if (k16 == 0) begin
      if (start16) begin
        k16   <= 1;
        res16 <= ref_mul(longint'(mc16), longint'(mp16), W16, eff_sgn(sgn16));
      end
    end else if (k16 == W16 + 3) begin
      k16 <= 0;
    end else begin
      k16 <= k16 + 1;
      if (k16 + 1 == W16 + 3) eprod16 <= res16;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy8",  64'(busy8),  64'(k8 >= 1 && k8 <= W8 + 2));
      chk("done8",  64'(done8),  64'(k8 == W8 + 3));
      chk("prod8",  64'(prod8),  64'(eprod8));
      chk("busy16", 64'(busy16), 64'(k16 >= 1 && k16 <= W16 + 2));
      chk("done16", 64'(done16), 64'(k16 == W16 + 3));
      chk("prod16", 64'(prod16), 64'(eprod16));
    end
  end

  // One operation: wait an idle cycle, request, track Busy/Done, check literal result.
  task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                        input bit sgn, input logic [31:0] lit, input bit hold,
                        input bit scramble, input string nm);
    int n, busy_n, w;
    bit seen;
    w = wide ? W16 : W8;
    @(negedge clk);
    if (wide) begin
      mc16 = a; mp16 = b; sgn16 = sgn; start16 = 1'b1;
    end else begin
      mc8 = a[7:0]; mp8 = b[7:0]; sgn8 = sgn; start8 = 1'b1;
    end
    n = 0; busy_n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (!hold) begin start8 = 1'b0; start16 = 1'b0; end
      if (scramble) begin
        mc8 = 8'($urandom); mp8 = 8'($urandom);
        mc16 = 16'($urandom); mp16 = 16'($urandom);
      end
      if (wide ? busy16 : busy8) busy_n++;
      if (wide ? done16 : done8) seen = 1'b1;
    end
    start8 = 1'b0; start16 = 1'b0;
    chk({nm, "_done_seen"}, 64'(seen), 64'(1));
    chk({nm, "_latency"},   64'(n),      64'(w + 3));
    chk({nm, "_busy_cyc"},  64'(busy_n), 64'(w + 2));
    chk({nm, "_product"},   wide ? 64'(prod16) : 64'(prod8), 64'(lit));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_busy8", 64'(busy8), 64'(0));
    chk("reset_done8", 64'(done8), 64'(0));
    chk("reset_prod8", 64'(prod8), 64'(0));
    chk("reset_prod16", 64'(prod16), 64'(0));
    rst = 1'b0;

    run_op(1'b0, 16'h0007, 16'h00FD, 1'b1, 32'h0000_FFEB, 1'b0, 1'b0, "s7xm3");
    run_op(1'b0, 16'h0080, 16'h0080, 1'b1, 32'h0000_4000, 1'b0, 1'b0, "m128sq");
    run_op(1'b0, 16'h0000, 16'h00FF, 1'b1, 32'h0000_0000, 1'b0, 1'b0, "zero_m1");
    run_op(1'b1, 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 1'b0, 1'b0, "w16");
`ifdef MULT_SIGNED_SEL_EN
    run_op(1'b0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01, 1'b0, 1'b0, "u255sq");
    run_op(1'b0, 16'h00FF, 16'h00FF, 1'b1, 32'h0000_0001, 1'b0, 1'b0, "s255sq");
`endif
    run_op(1'b0, 16'h000B, 16'h000D, 1'b1, 32'h0000_008F, 1'b1, 1'b0, "start_held");
    run_op(1'b0, 16'h00F6, 16'h0011, 1'b1, 32'h0000_FF56, 1'b0, 1'b1, "scramble");

    // Abort mid-run with Reset after 4 iterations.
    @(negedge clk);
    mc8 = 8'd100; mp8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy8), 64'(0));
    chk("abort_done", 64'(done8), 64'(0));
    chk("abort_prod", 64'(prod8), 64'(0));
    // Reset wins over a simultaneous Start.
    start8 = 1'b1;
    @(negedge clk);
    chk("rst_vs_start_busy", 64'(busy8), 64'(0));
    start8 = 1'b0;
    rst = 1'b0;
    run_op(1'b0, 16'h0005, 16'h0006, 1'b1, 32'h0000_001E, 1'b0, 1'b0, "fresh5x6");

    // Back-to-back operations; product holds in the gap.
    run_op(1'b0, 16'h0003, 16'h0004, 1'b1, 32'h0000_000C, 1'b0, 1'b0, "b2b_first");
    @(negedge clk);
    chk("b2b_hold", 64'(prod8), 64'h000C);
    run_op(1'b0, 16'h00FE, 16'h0009, 1'b1, 32'h0000_FFEE, 1'b0, 1'b0, "b2b_second");

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
